// File: rtl/xor_gate.sv
// Bitwise XOR with a combinational output and a registered path carrying
// parity, an inputs-differ flag and a saturating count of differing captures.
module xor_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             par_q,
  output logic             diff_q,
  output logic [CNT_W-1:0] diff_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] xor_w;
  logic             par_w;
  logic             diff_w;

  logic [WIDTH-1:0] y_d,   y_r;
  logic             par_d, par_r;
  logic             dif_d, dif_r;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Plain XOR so X/Z on any input bit shows up as X on the matching output bit.
  assign xor_w = a ^ b;
  assign par_w = ^xor_w;
  assign diff_w = |xor_w;

  assign y = xor_w;

  always_comb begin
    y_d   = y_r;
    par_d = par_r;
    dif_d = dif_r;
    cnt_d = cnt_q;
    if (en) begin
      y_d   = xor_w;
      par_d = par_w;
      dif_d = diff_w;
      if (diff_w && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_r   <= '0;
      par_r <= 1'b0;
      dif_r <= 1'b0;
      cnt_q <= '0;
    end else begin
      y_r   <= y_d;
      par_r <= par_d;
      dif_r <= dif_d;
      cnt_q <= cnt_d;
    end
  end

  assign y_q      = y_r;
  assign par_q    = par_r;
  assign diff_q   = dif_r;
  assign diff_cnt = cnt_q;

endmodule

// File: tb/tb_xor_gate.sv
// Directed bench for xor_gate: a 1-bit instance, an 8-bit instance with an
// 8-bit counter, and an 8-bit instance with a 2-bit counter for saturation.
module tb_xor_gate;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] a;
  logic [7:0] b;

  logic [0:0] y1, yq1;
  logic       par1, dif1;
  logic [7:0] cnt1;

  logic [7:0] y8, yq8;
  logic       par8, dif8;
  logic [7:0] cnt8;

  logic [7:0] ys, yqs;
  logic       pars, difs;
  logic [1:0] cnts;

  int pass_cnt;
  int total_cnt;

  xor_gate #(.WIDTH(1), .CNT_W(8)) u_w1 (
    .clk(clk), .rst(rst), .a(a[0:0]), .b(b[0:0]), .en(en),
    .y(y1), .y_q(yq1), .par_q(par1), .diff_q(dif1), .diff_cnt(cnt1)
  );

  xor_gate #(.WIDTH(8), .CNT_W(8)) u_w8 (
    .clk(clk), .rst(rst), .a(a), .b(b), .en(en),
    .y(y8), .y_q(yq8), .par_q(par8), .diff_q(dif8), .diff_cnt(cnt8)
  );

  xor_gate #(.WIDTH(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .a(a), .b(b), .en(en),
    .y(ys), .y_q(yqs), .par_q(pars), .diff_q(difs), .diff_cnt(cnts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One enabled/disabled edge; results sampled on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    #2;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [1:0] vec [4];
    logic       exp [4];
    vec = '{2'b00, 2'b01, 2'b10, 2'b11};
    exp = '{1'b0, 1'b1, 1'b1, 1'b0};
    rst = 1'b1;
    en  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = {7'd0, vec[i][1]};
      b = {7'd0, vec[i][0]};
      #10;
      total_cnt++;
      if (y1 !== exp[i]) $display("FAIL reset_truth[%0d]: y=%b expected %b", i, y1, exp[i]);
      else pass_cnt++;
      total_cnt++;
      if ({yq1, par1, dif1, cnt1} !== 11'd0)
        $display("FAIL reset_regs_w1[%0d]: got %h expected 0", i, {yq1, par1, dif1, cnt1});
      else pass_cnt++;
    end
    total_cnt++;
    if ({yq8, par8, dif8, cnt8} !== 18'd0)
      $display("FAIL reset_regs_w8: got %h expected 0", {yq8, par8, dif8, cnt8});
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_capture();
    do_reset();
    a  = 8'hA5;
    b  = 8'h0F;
    en = 1'b1;
    #1;
    total_cnt++;
    if (y8 !== 8'hAA) $display("FAIL capture_comb: y=%h expected aa", y8);
    else pass_cnt++;
    total_cnt++;
    if (yq8 !== 8'h00) $display("FAIL capture_pre_edge: y_q=%h expected 00", yq8);
    else pass_cnt++;
    step();
    total_cnt++;
    if (yq8 !== 8'hAA) $display("FAIL capture_yq: y_q=%h expected aa", yq8);
    else pass_cnt++;
    total_cnt++;
    if ({par8, dif8} !== 2'b01) $display("FAIL capture_flags: par,diff=%b expected 01", {par8, dif8});
    else pass_cnt++;
    total_cnt++;
    if (cnt8 !== 8'd1) $display("FAIL capture_cnt: diff_cnt=%0d expected 1", cnt8);
    else pass_cnt++;
  endtask

  task automatic test_equal_then_diff();
    do_reset();
    en = 1'b1;
    a  = 8'h3C;
    b  = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if ({yq8, par8, dif8, cnt8} !== {8'h00, 1'b0, 1'b0, 8'd0})
        $display("FAIL equal[%0d]: y_q=%h par=%b diff=%b cnt=%0d expected 00 0 0 0", i, yq8, par8, dif8, cnt8);
      else pass_cnt++;
    end
    a = 8'h3D;
    for (int i = 0; i < 2; i++) begin
      step();
      total_cnt++;
      if ({yq8, par8, dif8, cnt8} !== {8'h01, 1'b1, 1'b1, 8'(i + 1)})
        $display("FAIL differ[%0d]: y_q=%h par=%b diff=%b cnt=%0d expected 01 1 1 %0d", i, yq8, par8, dif8, cnt8, i + 1);
      else pass_cnt++;
    end
  endtask

  task automatic test_hold();
    logic [7:0] av [4];
    logic [7:0] bv [4];
    logic [7:0] ev [4];
    av = '{8'hFF, 8'h00, 8'h55, 8'h81};
    bv = '{8'h00, 8'h00, 8'hAA, 8'h18};
    ev = '{8'hFF, 8'h00, 8'hFF, 8'h99};
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = av[i];
      b = bv[i];
      #1;
      total_cnt++;
      if (y8 !== ev[i]) $display("FAIL hold_comb[%0d]: y=%h expected %h", i, y8, ev[i]);
      else pass_cnt++;
      step();
      total_cnt++;
      if ({yq8, par8, dif8, cnt8} !== {8'h01, 1'b1, 1'b1, 8'd2})
        $display("FAIL hold_regs[%0d]: y_q=%h par=%b diff=%b cnt=%0d expected 01 1 1 2", i, yq8, par8, dif8, cnt8);
      else pass_cnt++;
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp [5];
    exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    en = 1'b1;
    a  = 8'h01;
    b  = 8'h00;
    for (int i = 0; i < 5; i++) begin
      step();
      total_cnt++;
      if (cnts !== exp[i]) $display("FAIL saturate[%0d]: diff_cnt=%0d expected %0d", i, cnts, exp[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({yqs, pars, difs, cnts} !== 12'd0)
      $display("FAIL async_reset_regs: got %h expected 0", {yqs, pars, difs, cnts});
    else pass_cnt++;
    total_cnt++;
    if (ys !== 8'h01) $display("FAIL async_reset_comb: y=%h expected 01", ys);
    else pass_cnt++;
  endtask

  task automatic test_release();
    @(negedge clk);
    total_cnt++;
    if (cnts !== 2'd0) $display("FAIL release_held: diff_cnt=%0d expected 0", cnts);
    else pass_cnt++;
    rst = 1'b0;
    step();
    total_cnt++;
    if ({yqs, pars, difs, cnts} !== {8'h01, 1'b1, 1'b1, 2'd1})
      $display("FAIL release_resume: y_q=%h par=%b diff=%b cnt=%0d expected 01 1 1 1", yqs, pars, difs, cnts);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst = 1'b1;
    en  = 1'b0;
    a   = 8'h00;
    b   = 8'h00;
    test_reset();
    test_capture();
    test_equal_then_diff();
    test_hold();
    test_saturate();
    test_async_reset();
    test_release();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/xor_gate.md
Name: xor_gate

Overview:
- Bitwise two-input XOR unit with a zero-latency combinational output plus a registered result path.
- The registered path adds a parity flag and a saturating count of "inputs differ" events.
- Used as a basic logic primitive and as a difference/parity detector between two equal-width buses.
- One clock domain, `clk`; asynchronous active-high reset, `rst`.

Parameters:
- WIDTH, 1, bit width of operands a, b and results y, y_q.
- CNT_W, 8, width of the saturating difference counter diff_cnt.

Ports:
- clk  input  1  rising-edge clock for all registers.
- rst  input  1  asynchronous, active-high reset; clears all registers immediately on assertion.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- y  output  WIDTH  combinational a XOR b.
- en  input  1  capture enable for the registered path.
- y_q  output  WIDTH  registered a XOR b.
- par_q  output  1  registered reduction-XOR (odd parity) of a XOR b.
- diff_q  output  1  registered flag: 1 when a != b at the last enabled capture.
- diff_cnt  output  CNT_W  saturating count of enabled cycles with a != b.

Behaviour:
- y = a ^ b bitwise, purely combinational, 0 clock latency.
- y is independent of clk, rst and en; it is valid during reset.
- For WIDTH=1, the truth table of y is: 00->0, 01->1, 10->1, 11->0.
- X/Z on an input bit propagates as X on the corresponding y bit. No masking.
- Reset (rst=1, asynchronous assert): y_q=0, par_q=0, diff_q=0, diff_cnt=0. All are held while rst=1.
- Reset deassertion is synchronous to clk. The first capture is possible on the first rising edge after rst is low.
- On a rising clk edge with rst=0 and en=1:
  - y_q <= a ^ b.
  - par_q <= ^(a ^ b).
  - diff_q <= |(a ^ b).
  - diff_cnt <= diff_cnt + 1 if |(a ^ b) and diff_cnt != all-ones; otherwise diff_cnt holds.
- On a rising edge with en=0: all registers hold.
- Latency of the registered outputs is 1 cycle from the inputs sampled at the enabled edge.
- Saturation: diff_cnt stops at 2^CNT_W - 1 and never wraps.
- Reset mid-operation: all registers clear immediately, regardless of en or clk.
- rst has priority over en.
- Simultaneous input change and clock edge: the registers take the values present at the edge (standard setup/hold applies).
- No internal state affects y.

Test Plan:
- WIDTH=1, rst=1, en=0; apply a/b = 00, 01, 10, 11, each for 10 ns -> y = 0, 1, 1, 0 after each step. Check with a case-equality compare (no X allowed).
- WIDTH=8, en=1; a=8'hA5, b=8'h0F, then one clk edge -> y=8'hAA immediately; after the edge y_q=8'hAA, par_q=0, diff_q=1, diff_cnt=1.
- WIDTH=8, en=1; a=b=8'h3C for 3 cycles, then a=8'h3D for 2 cycles -> diff_q goes 0 then 1; diff_cnt ends at 2; par_q=1 during the last two cycles.
- en=0 for 4 cycles while a/b toggle -> y tracks the inputs; y_q, par_q, diff_q and diff_cnt are unchanged.
- CNT_W=2, en=1, a != b for 5 cycles -> diff_cnt = 1, 2, 3, 3, 3 (saturates, no wrap).
- Assert rst asynchronously between clk edges with diff_cnt=3 -> y_q, par_q, diff_q and diff_cnt go to 0 without waiting for a clk edge, while y still equals a^b.
- Release rst -> counting resumes from 0 on the next enabled edge.
